// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter in front of a single shared slave.
// Ownership is granted one cycle after a request is first seen and is held for
// as long as the owner keeps cyc asserted. A per-transfer wait counter forces
// an error termination when the slave does not respond within TIMEOUT_CYCLES.
module wb_arbiter_2m #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   // master 0
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_rty_o,

   // master 1
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_rty_o,

   // shared slave
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,

   // status
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN_M0 = 2'd1,
      ST_OWN_M1 = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_prio;          // 0: M0 wins a tie in IDLE, 1: M1 wins
   logic        w_prio_nxt;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  w_wait_cnt_nxt;

   logic        w_own0;
   logic        w_own1;
   logic        w_own_req;       // owner has cyc and stb asserted
   logic        w_slv_term;
   logic        w_cnt_hit;
   logic        w_force_err;

   // Decode ownership and the timeout condition from the registered state.
   always_comb begin
      w_own0     = (r_state == ST_OWN_M0);
      w_own1     = (r_state == ST_OWN_M1);
      w_own_req  = (w_own0 & m0_cyc_i & m0_stb_i) | (w_own1 & m1_cyc_i & m1_stb_i);
      w_slv_term = s_ack_i | s_err_i | s_rty_i;
      w_cnt_hit  = (r_wait_cnt == TIMEOUT_LIMIT);
      // A real slave termination in the timeout cycle takes precedence.
      w_force_err = w_own_req & w_cnt_hit & ~w_slv_term;
   end

   // State, priority pointer and wait counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_prio     <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_prio     <= w_prio_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Next-state and priority logic: bus lock while cyc is held, direct handover.
   always_comb begin
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;
      unique case (r_state)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               w_state_nxt = r_prio ? ST_OWN_M1 : ST_OWN_M0;
            end else if (m0_cyc_i) begin
               w_state_nxt = ST_OWN_M0;
            end else if (m1_cyc_i) begin
               w_state_nxt = ST_OWN_M1;
            end
         end
         ST_OWN_M0: begin
            if (!m0_cyc_i) begin
               w_prio_nxt  = 1'b1;
               w_state_nxt = m1_cyc_i ? ST_OWN_M1 : ST_IDLE;
            end
         end
         ST_OWN_M1: begin
            if (!m1_cyc_i) begin
               w_prio_nxt  = 1'b0;
               w_state_nxt = m0_cyc_i ? ST_OWN_M0 : ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Wait counter: counts owner strobe cycles without a slave termination,
   // restarting after a forced error so it never passes the limit.
   always_comb begin
      if (!w_own_req || w_slv_term || w_cnt_hit) begin
         w_wait_cnt_nxt = '0;
      end else begin
         w_wait_cnt_nxt = r_wait_cnt + 8'd1;
      end
   end

   // Output mux: route the owner to the slave and slave responses to the owner.
   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      m0_dat_o  = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m0_rty_o  = 1'b0;
      m1_dat_o  = '0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      m1_rty_o  = 1'b0;
      grant_o   = {w_own1, w_own0};
      timeout_o = w_force_err;

      if (w_own0) begin
         s_cyc_o  = m0_cyc_i;
         s_stb_o  = m0_stb_i & ~w_force_err;
         s_we_o   = m0_we_i;
         s_adr_o  = m0_adr_i;
         s_dat_o  = m0_dat_i;
         s_sel_o  = m0_sel_i;
         m0_dat_o = s_dat_i;
         m0_ack_o = s_ack_i;
         m0_err_o = s_err_i | w_force_err;
         m0_rty_o = s_rty_i;
      end else if (w_own1) begin
         s_cyc_o  = m1_cyc_i;
         s_stb_o  = m1_stb_i & ~w_force_err;
         s_we_o   = m1_we_i;
         s_adr_o  = m1_adr_i;
         s_dat_o  = m1_dat_i;
         s_sel_o  = m1_sel_i;
         m1_dat_o = s_dat_i;
         m1_ack_o = s_ack_i;
         m1_err_o = s_err_i | w_force_err;
         m1_rty_o = s_rty_i;
      end
   end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: wait cycles allowed for slave termination before the arbiter forces an error; legal range 2..255.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 mN_cyc_i, mN_stb_i, mN_we_i (N=0,1)  input  1 each  Wishbone master N cycle/strobe/write.
REQ-005 mN_adr_i [31:0], mN_dat_i [31:0], mN_sel_i [3:0]  input  master N address/write data/byte select.
REQ-006 mN_dat_o [31:0], mN_ack_o, mN_err_o, mN_rty_o  output  master N read data and terminations.
REQ-007 s_cyc_o, s_stb_o, s_we_o  output  1 each  shared slave (SPRAM) cycle/strobe/write.
REQ-008 s_adr_o [31:0], s_dat_o [31:0], s_sel_o [3:0]  output  slave address/write data/byte select.
REQ-009 s_dat_i [31:0], s_ack_i, s_err_i, s_rty_i  input  slave read data and terminations.
REQ-010 grant_o  output  2  one-hot current owner (01=M0, 10=M1, 00=none).
REQ-011 timeout_o  output  1  one-cycle pulse when a forced timeout error is issued.

Function
REQ-012 FSM states: IDLE, OWN_M0, OWN_M1; grant_o = {state==OWN_M1, state==OWN_M0}.
REQ-013 IDLE: one master's cyc_i high -> that master's OWN state next cycle; both high -> the master indicated by priority pointer prio (0=M0, 1=M1); neither -> stay IDLE.
REQ-014 Arbitration latency exactly one cycle: no slave signal driven active in the cycle a request is first seen in IDLE.
REQ-015 OWN_Mx: ownership held for as long as mx_cyc_i is high, regardless of stb_i/terminations (bus lock for multi-beat cycles).
REQ-016 OWN_Mx with mx_cyc_i low: if the other master's cyc_i is high -> OWN_other next cycle (no IDLE bubble), else -> IDLE; prio set to the master not just served.
REQ-017 While OWN_Mx: s_cyc_o=mx_cyc_i, s_stb_o=mx_stb_i & ~force_err, s_we_o/adr/dat/sel = master x values combinationally.
REQ-018 While IDLE: s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=s_dat_o=0, s_sel_o=0.
REQ-019 Owner: mx_dat_o=s_dat_i, mx_ack_o=s_ack_i, mx_rty_o=s_rty_i, mx_err_o=s_err_i | force_err, combinationally.
REQ-020 Non-owner (and both in IDLE): dat_o=0, ack_o=err_o=rty_o=0; slave terminations arriving in IDLE ignored.
REQ-021 Wait counter (8-bit): clears when state is not OWN, owner stb_i low, or any s_ack_i/s_err_i/s_rty_i high; otherwise increments by 1 per cycle.
REQ-022 force_err = counter == TIMEOUT_CYCLES (registered compare); in that cycle owner err_o=1, s_stb_o=0, timeout_o=1, counter clears next cycle.
REQ-023 force_err coincident with slave ack: slave termination wins, force_err suppressed, timeout_o=0.
REQ-024 Counter saturates logic: never wraps past TIMEOUT_CYCLES.
REQ-025 Owner dropping cyc_i with a slave ack in the same cycle: ack still routed to owner that cycle; handover per REQ-016.

Reset
REQ-026 rst_ni low: immediately state=IDLE, prio=0, counter=0, all registered outputs 0; combinational outputs follow REQ-018/020 (grant_o=00, timeout_o=0).
REQ-027 Reset asserted mid-transfer abandons the transfer; no termination is delivered to the interrupted master.
REQ-028 Release on clock edge with requests pending: arbitration per REQ-013 from the first edge after release.

Verification
REQ-029 M0 read alone, slave acks 1 cycle after stb -> grant_o=01 one cycle after m0_cyc_i, m0_ack_o=1 with m0_dat_o=s_dat_i, M1 outputs all 0.
REQ-030 M0 and M1 request same cycle from reset -> M0 owns first; M0 drops cyc_i -> grant_o=10 next cycle with no IDLE cycle; repeat -> M1 then M0 alternate.
REQ-031 M1 holds cyc_i across 4 acked beats while M0 requests -> grant_o stays 10 all 4 beats; M0 sees no ack/err.
REQ-032 Owner stb_i high, slave never terminates, TIMEOUT_CYCLES=15 -> err_o and timeout_o high for exactly one cycle after 15 wait cycles, s_stb_o low that cycle.
REQ-033 Slave ack on exactly the timeout cycle -> ack delivered, err_o=0, timeout_o=0.
REQ-034 rst_ni pulsed low mid-transfer of M1 -> grant_o=00, s_cyc_o=0 asynchronously, no ack to M1; after release, pending M0 request granted first.
